// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: panel button decode, hurricane/self-clean countdowns, hand_clean pulse.
// Optional HURR_REARM_EN: re-arms the hurricane budget on every OFF->STANDBY power-up.
module hood_mode_ctrl #(
  parameter int HURR_SECS  = 60,
  parameter int CLEAN_SECS = 180
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       power_btn,
  input  logic       menu_btn,
  input  logic       gear1_btn,
  input  logic       gear2_btn,
  input  logic       gear3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode_state,
  output logic       machine_state,
  output logic       hurricane_avail,
  output logic [7:0] countdown_sec,
  output logic       hand_clean
);

  typedef enum logic [2:0] {S_OFF, S_STBY, S_G1, S_G2, S_G3, S_CLEAN} state_t;

  state_t     state_q, state_d;
  logic [5:0] btn, btn_q, e;
  logic [7:0] cnt_d;
  logic       avail_d, mexit_q, mexit_d, hand_d;
  logic [2:0] mode_d;

  // bit order is the priority order: power, menu, clean, gear3, gear2, gear1
  assign btn = {power_btn, menu_btn, clean_btn, gear3_btn, gear2_btn, gear1_btn};
  assign e   = btn & ~btn_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = countdown_sec;
    avail_d = hurricane_avail;
    mexit_d = mexit_q;
    hand_d  = 1'b0;
    case (state_q)
      S_OFF: if (e[5]) begin
        state_d = S_STBY;
`ifdef HURR_REARM_EN
        avail_d = 1'b1;
`endif
      end
      S_STBY, S_G1, S_G2: begin
        if (e[5]) begin
          state_d = S_OFF;
          cnt_d   = 8'd0;
          mexit_d = 1'b0;
        end else if (e[4] && state_q != S_STBY) begin
          state_d = S_STBY;
        end else if (e[3] && state_q == S_STBY) begin
          state_d = S_CLEAN;
          cnt_d   = 8'(CLEAN_SECS);
        end else if (e[2]) begin
          if (hurricane_avail) begin
            state_d = S_G3;
            cnt_d   = 8'(HURR_SECS);
            avail_d = 1'b0;
          end
        end else if (e[1]) begin
          state_d = S_G2;
        end else if (e[0]) begin
          state_d = S_G1;
        end
      end
      S_G3: begin
        if (e[5]) begin
          state_d = S_OFF;
          cnt_d   = 8'd0;
          mexit_d = 1'b0;
        end else begin
          if (e[4]) mexit_d = 1'b1;
          if (countdown_sec <= 8'd1) begin
            // menu during hurricane only chooses where the timed exit lands
            state_d = mexit_q ? S_STBY : S_G2;
            cnt_d   = 8'd0;
            mexit_d = 1'b0;
          end else begin
            cnt_d = countdown_sec - 8'd1;
          end
        end
      end
      S_CLEAN: begin
        if (e[5]) begin
          state_d = S_OFF;
          cnt_d   = 8'd0;
          mexit_d = 1'b0;
        end else if (countdown_sec <= 8'd1) begin
          state_d = S_STBY;
          cnt_d   = 8'd0;
          hand_d  = 1'b1;
        end else begin
          cnt_d = countdown_sec - 8'd1;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = 8'd0;
        mexit_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mode_d = 3'b000;
    case (state_d)
      S_G1:    mode_d = 3'b001;
      S_G2:    mode_d = 3'b010;
      S_G3:    mode_d = 3'b011;
      S_CLEAN: mode_d = 3'b100;
      default: mode_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q         <= S_OFF;
      btn_q           <= '0;
      mexit_q         <= 1'b0;
      mode_state      <= 3'b000;
      machine_state   <= 1'b0;
      hurricane_avail <= 1'b1;
      countdown_sec   <= 8'd0;
      hand_clean      <= 1'b0;
    end else begin
      state_q         <= state_d;
      btn_q           <= btn;
      mexit_q         <= mexit_d;
      mode_state      <= mode_d;
      machine_state   <= (state_d != S_OFF);
      hurricane_avail <= avail_d;
      countdown_sec   <= cnt_d;
      hand_clean      <= hand_d;
    end
  end

endmodule
